ysyx_20020207_mdu: RTL
======================

Name: ysyx_20020207_mdu

Overview:
- Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage.
- The decoder steers op 7'b0110011 with funct7=0000001 here instead of the ALU.
- Operands and a destination tag are accepted over a valid/ready handshake; one result is returned over a second handshake.
- Multi-cycle, single operation in flight, flushable on jump/trap.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even, ≥ 8.
- TAG_WIDTH, 5, width of the pass-through destination tag (rd index).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- func  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  in  DATA_WIDTH  rs1 operand.
- src2  in  DATA_WIDTH  rs2 operand.
- tag_in  in  TAG_WIDTH  destination tag.
- flush  in  1  kill any in-flight or completed-but-unconsumed operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  DATA_WIDTH  operation result.
- tag_out  out  TAG_WIDTH  tag captured with the request.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; tag_out=0; counter=0; all internal accumulators 0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready&&!flush: capture func, tag_in, operand magnitudes and sign flags.
  - Signedness by op:
    - MULH: both operands signed.
    - MULHSU: src1 signed, src2 unsigned.
    - DIV/REM: both signed.
    - All others: unsigned.
  - Next state by op:
    - func[2]=0 → MUL.
    - func[2]=1 and src2==0 → DONE; result = all-ones for DIV/DIVU, src1 for REM/REMU.
    - Signed DIV/REM with src1=100..0 and src2=all-ones → DONE; result = src1 for DIV, 0 for REM.
    - Otherwise → DIV.
- MUL:
  - Radix-2 shift-add on unsigned magnitudes into a 2*DATA_WIDTH accumulator.
  - One multiplier bit per cycle, exactly DATA_WIDTH cycles, counter 0..DATA_WIDTH-1, then → DONE.
  - Final 2W product is negated if the operand signs differ (signed operands only).
  - MUL returns the low W bits; MULH/MULHSU/MULHU return the high W bits.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, exactly DATA_WIDTH cycles, then → DONE.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Negation is applied when entering DONE.
- DONE:
  - out_valid=1; result and tag_out held stable; in_ready=0.
  - On out_ready → IDLE; out_valid drops next cycle.
  - A new request is not accepted in the same cycle as out_ready (in_ready is 0 in DONE).
- Latency, counting the accept edge as edge 0:
  - Normal ops: out_valid=1 after edge DATA_WIDTH+1, i.e. 33 cycles for W=32.
  - Special cases (divide-by-zero, signed overflow): out_valid=1 after edge 1.
- Flush (synchronous, any state):
  - Next state=IDLE; out_valid=0 next cycle; counter cleared; result/tag_out not updated.
  - A request presented with flush=1 in IDLE is not accepted.
  - Flush beats out_ready in the same cycle; the result is discarded and counts as not consumed.
- Reset mid-operation: immediate return to reset values; no result is produced.
- Width rules:
  - Accumulators are 2*DATA_WIDTH; the remainder register is DATA_WIDTH+1 to hold the trial-subtract borrow.
  - Magnitude of the most negative value is 100..0, treated as unsigned.
- Outputs in IDLE/MUL/DIV: result and tag_out hold the last delivered values; out_valid=0.

Test Plan:
- MUL/MULHU: src1=0xFFFF_FFFF, src2=0xFFFF_FFFF, tag=7.
  - MUL → result=0x0000_0001, tag_out=7.
  - MULHU → 0xFFFF_FFFE.
  - out_valid exactly 33 cycles after accept.
- MULH/MULHSU: src1=0xFFFF_FFFF (-1), src2=0xFFFF_FFFF.
  - MULH → 0x0000_0000.
  - MULHSU → 0xFFFF_FFFF.
  - MULH with 0x8000_0000 × 0x8000_0000 → 0x4000_0000.
- DIV/REM signs: src1=-7 (0xFFFF_FFF9), src2=2.
  - DIV → 0xFFFF_FFFD (-3).
  - REM → 0xFFFF_FFFF (-1).
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with out_valid 1 cycle after accept:
  - DIVU 5/0 → 0xFFFF_FFFF.
  - REM 5/0 → 5.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000.
  - REM 0x8000_0000 / 0xFFFF_FFFF → 0.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - result/tag_out stable, in_ready=0.
  - Raise out_ready → IDLE next cycle; next request accepted the cycle after.
- Flush and reset:
  - flush at cycle 12 of a DIV → IDLE next cycle, no out_valid.
  - flush together with out_ready in DONE → result discarded.
  - rst_n low at cycle 20 of a MUL → immediate reset values; a subsequent MUL 3×5 → 15.

Source files
------------

// File: rtl/ysyx_20020207_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one operation in flight, valid/ready on both sides.
module ysyx_20020207_mdu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            func,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic                  busy
);
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned W2    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       func_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic             neg_q;
    logic             rneg_q;
    logic [W2-1:0]    acc;
    logic [W:0]       rem;
    logic [W-1:0]     res_q;

    // Request decode: signedness, magnitudes and the two division special cases
    logic         s1_signed, s2_signed, s1_neg, s2_neg;
    logic [W-1:0] src1_mag, src2_mag;
    logic         div_zero, div_ovf;

    always_comb begin
        s1_signed = (func == 3'b001) || (func == 3'b010) || (func == 3'b100) || (func == 3'b110);
        s2_signed = (func == 3'b001) || (func == 3'b100) || (func == 3'b110);
        s1_neg    = s1_signed && src1[W-1];
        s2_neg    = s2_signed && src2[W-1];
        src1_mag  = s1_neg ? W'(-src1) : src1;
        src2_mag  = s2_neg ? W'(-src2) : src2;
        div_zero  = func[2] && (src2 == '0);
        div_ovf   = func[2] && !func[0] && (src1 == {1'b1, {(W-1){1'b0}}}) && (src2 == '1);
    end

    // One iteration step of each datapath plus final sign fix-up
    logic [W:0]    mul_sum;
    logic [W2-1:0] mul_acc_nx, prod;
    logic [W+1:0]  div_cmp;
    logic          div_ge;
    logic [W-1:0]  div_rem_nx, div_quo_nx, quo_fix, rem_fix;

    always_comb begin
        mul_sum    = {1'b0, acc[W2-1:W]} + {1'b0, a_mag & {W{acc[0]}}};
        mul_acc_nx = {mul_sum, acc[W-1:1]};
        prod       = neg_q ? W2'(-mul_acc_nx) : mul_acc_nx;
        div_cmp    = {rem, acc[W-1]};
        div_ge     = div_cmp >= {2'b00, b_mag};
        div_rem_nx = div_ge ? W'(div_cmp - {2'b00, b_mag}) : W'(div_cmp);
        div_quo_nx = {acc[W-2:0], div_ge};
        quo_fix    = neg_q ? W'(-div_quo_nx) : div_quo_nx;
        rem_fix    = rneg_q ? W'(-div_rem_nx) : div_rem_nx;
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            func_q    <= '0;
            tag_q     <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            acc       <= '0;
            rem       <= '0;
            res_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        func_q   <= func;
                        tag_q    <= tag_in;
                        a_mag    <= src1_mag;
                        b_mag    <= src2_mag;
                        neg_q    <= s1_neg ^ s2_neg;
                        rneg_q   <= s1_neg;
                        cnt      <= '0;
                        rem      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (!func[2]) begin
                            acc   <= {{W{1'b0}}, src2_mag};
                            state <= MUL;
                        end else if (div_zero) begin
                            res_q <= func[1] ? src1 : '1;
                            state <= DONE;
                        end else if (div_ovf) begin
                            res_q <= func[1] ? '0 : src1;
                            state <= DONE;
                        end else begin
                            acc   <= {{W{1'b0}}, src1_mag};
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(W - 1)) begin
                        res_q <= (func_q == 3'b000) ? prod[W-1:0] : prod[W2-1:W];
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                DIV: begin
                    acc[W-1:0] <= div_quo_nx;
                    rem        <= {1'b0, div_rem_nx};
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_W'(W - 1)) begin
                        res_q <= func_q[1] ? rem_fix : quo_fix;
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; handshake completes afterwards
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        result    <= res_q;
                        tag_out   <= tag_q;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
